// File: rtl/output_requantizer.sv
// Output requantizer: rounds and arithmetically right-shifts wide signed accumulator
// words by OUT_SCALE, then saturates them to OUT_WIDTH bits.
// Two-stage stall-able valid/ready pipeline with a saturating count of clipped words.
module output_requantizer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned OUT_SCALE = 0
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    input  logic                 clear_sat,
    output logic [15:0]          sat_count
);

    // One extra bit of headroom so the rounding bias can never overflow.
    localparam int unsigned SW = IN_WIDTH + 1;

    // The shift amount for the bias is clamped at 0 so the unused branch stays legal.
    localparam int unsigned BiasShift = (OUT_SCALE > 0) ? OUT_SCALE - 1 : 0;
    localparam logic [SW-1:0] RoundBias = (OUT_SCALE > 0) ? (SW'(1) << BiasShift) : '0;

    // Representable output range, sign-extended to the S1 width.
    localparam logic signed [SW-1:0] SatMax =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [SW-1:0] SatMin =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic                 s1_v_q;
    logic signed [SW-1:0] s1_q;
    logic signed [SW-1:0] s1_d;
    logic [SW-1:0]        in_biased;

    logic                 s2_v_q;
    logic [OUT_WIDTH-1:0] s2_data_q;
    logic [OUT_WIDTH-1:0] s2_data_d;
    logic                 s2_sat_q;
    logic                 s2_sat_d;

    logic [15:0]          sat_cnt_q;
    logic [15:0]          sat_cnt_d;

    logic                 s1_adv;
    logic                 s2_adv;

    // Handshake: a stage advances when it is empty or the stage after it advances.
    always_comb begin
        s2_adv   = !s2_v_q || out_ready;
        s1_adv   = !s1_v_q || s2_adv;
        in_ready = s1_adv;
    end

    // Round-half-up then arithmetic shift; OUT_SCALE=0 passes the word through.
    always_comb begin
        in_biased = {in_data[IN_WIDTH-1], in_data} + RoundBias;
        s1_d      = $signed(in_biased) >>> OUT_SCALE;
    end

    // Stage 1 register: rounded, shifted value.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else if (s1_adv) begin
            s1_v_q <= in_valid;
            s1_q   <= s1_d;
        end
    end

    // Clip the S1 value to the signed output range.
    always_comb begin
        s2_data_d = s1_q[OUT_WIDTH-1:0];
        s2_sat_d  = 1'b0;
        if (s1_q > SatMax) begin
            s2_data_d = SatMax[OUT_WIDTH-1:0];
            s2_sat_d  = 1'b1;
        end else if (s1_q < SatMin) begin
            s2_data_d = SatMin[OUT_WIDTH-1:0];
            s2_sat_d  = 1'b1;
        end
    end

    // Stage 2 register: saturated output word and its clip flag.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_sat_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_v_q    <= s1_v_q;
            s2_data_q <= s2_data_d;
            s2_sat_q  <= s2_sat_d;
        end
    end

    // Count clipped words as they load into S2; sticks at all-ones, clear wins.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (clear_sat) begin
            sat_cnt_d = '0;
        end else if (s2_adv && s1_v_q && s2_sat_d && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Drive outputs straight from S2 so they are stable while stalled.
    always_comb begin
        out_valid = s2_v_q;
        out_data  = s2_data_q;
        out_sat   = s2_sat_q;
        sat_count = sat_cnt_q;
    end

endmodule
